// File: rtl/rf_pkg.sv
// Shared types and constants for the transceiver SPI scheduler: engine modes,
// FSM states, the power-up register-write table and the INTSTAT address.
package rf_pkg;

    typedef enum logic [1:0] {
        SHORT_RD = 2'b00,
        SHORT_WR = 2'b01,
        LONG_RD  = 2'b10,
        LONG_WR  = 2'b11
    } rf_mode_e;

    typedef enum logic [2:0] {
        S_RST_WAIT,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } rf_state_e;

    typedef struct packed {
        logic       is_long;
        logic [9:0] addr;
        logic [7:0] data;
    } init_entry_t;

    localparam int INIT_LEN   = 3;
    localparam int INIT_IDX_W = $clog2(INIT_LEN + 1);

    localparam init_entry_t [0:INIT_LEN-1] INIT_TABLE = '{
        '{1'b0, 10'h02A, 8'h07},
        '{1'b1, 10'h222, 8'h01},
        '{1'b0, 10'h011, 8'hFF}
    };

    localparam logic [9:0] INTSTAT_ADDR = 10'h031;

    function automatic rf_mode_e wr_mode(input logic is_long);
        return is_long ? LONG_WR : SHORT_WR;
    endfunction

endpackage

// File: rtl/rf_sdo_deser.sv
// Serial read-data capture: shifts eng_sdo in MSB first while the engine is busy;
// the low byte at completion is the register value read.
module rf_sdo_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_shift_en,
    input  logic       i_sdo,
    output logic [7:0] o_byte
);

    logic [7:0] r_shift;
    logic [7:0] w_shift_next;

    assign w_shift_next[0] = i_sdo;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_shift
            assign w_shift_next[gi] = r_shift[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
        end else if (i_shift_en) begin
            r_shift <= w_shift_next;
        end
    end

    assign o_byte = r_shift;

endmodule

// File: rtl/rf_spi_sched.sv
// Init sequencer plus host/interrupt arbiter in front of the SPI register engine.
// Optional busy timeout with engine abort is built when RF_SPI_SCHED_TIMEOUT_EN is defined.
module rf_spi_sched
    import rf_pkg::*;
#(
    parameter int RST_WAIT       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rf_intr,
    input  logic       i_host_req,
    input  logic       i_host_we,
    input  logic       i_host_long,
    input  logic [9:0] i_host_addr,
    input  logic [7:0] i_host_wdata,
    output logic       o_host_ack,
    output logic [7:0] o_host_rdata,
    output logic       o_irq_valid,
    output logic [7:0] o_irq_status,
    output logic       o_init_done,
    output logic       o_err,
    output logic       o_eng_c_en,
    output logic [1:0] o_eng_mode,
    output logic [9:0] o_eng_addr,
    output logic [7:0] o_eng_data,
    output logic       o_eng_abort,
    input  logic       i_eng_ready,
    input  logic       i_eng_sdo
);

    localparam int CNT_MAX = (RST_WAIT > TIMEOUT_CYCLES) ? RST_WAIT : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    rf_state_e              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [INIT_IDX_W-1:0]  r_idx;
    logic                   r_seen_busy;
    logic                   r_last_irq;
    logic                   r_cur_host;
    logic                   r_cur_we;
    logic                   r_c_en;
    rf_mode_e               r_mode;
    logic [9:0]             r_addr;
    logic [7:0]             r_data;
    logic                   r_host_ack;
    logic [7:0]             r_host_rdata;
    logic                   r_irq_valid;
    logic [7:0]             r_irq_status;
    logic                   r_init_done;

    logic [INIT_IDX_W-1:0]  w_next_idx;
    init_entry_t            w_next_entry;
    logic                   w_in_wait;
    logic                   w_done;
    logic                   w_timeout;
    logic                   w_irq_win;
    logic [7:0]             w_rd_byte;

    assign w_next_idx   = r_idx + 1'b1;
    assign w_next_entry = INIT_TABLE[w_next_idx];
    assign w_in_wait    = (r_state == S_WAIT) || (r_state == S_INIT_WAIT);
    // Completion needs the engine to have been seen busy at least once since issue.
    assign w_done       = w_in_wait && i_eng_ready && r_seen_busy;
    assign w_irq_win    = i_rf_intr && !(r_last_irq && i_host_req);

    rf_sdo_deser u_deser (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_c_en),
        .i_shift_en (!i_eng_ready),
        .i_sdo      (i_eng_sdo),
        .o_byte     (w_rd_byte)
    );

`ifdef RF_SPI_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] r_tmo;
    logic             r_abort;
    logic             r_err;

    assign w_timeout = w_in_wait && !w_done && (r_tmo == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo   <= '0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_abort <= w_timeout;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            r_tmo <= w_in_wait ? r_tmo + 1'b1 : '0;
        end
    end

    assign o_eng_abort = r_abort;
    assign o_err       = r_err;
`else
    assign w_timeout   = 1'b0;
    assign o_eng_abort = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RST_WAIT;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_seen_busy  <= 1'b0;
            r_last_irq   <= 1'b0;
            r_cur_host   <= 1'b0;
            r_cur_we     <= 1'b0;
            r_c_en       <= 1'b0;
            r_mode       <= SHORT_RD;
            r_addr       <= '0;
            r_data       <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_irq_valid  <= 1'b0;
            r_irq_status <= '0;
            r_init_done  <= 1'b0;
        end else begin
            r_c_en      <= 1'b0;
            r_host_ack  <= 1'b0;
            r_irq_valid <= 1'b0;
            if (w_in_wait && !i_eng_ready) begin
                r_seen_busy <= 1'b1;
            end
            case (r_state)
                S_RST_WAIT: begin
                    if (r_cnt == CNT_W'(RST_WAIT)) begin
                        r_state <= S_INIT_ISSUE;
                        r_idx   <= '0;
                        r_c_en  <= 1'b1;
                        r_mode  <= wr_mode(INIT_TABLE[0].is_long);
                        r_addr  <= INIT_TABLE[0].addr;
                        r_data  <= INIT_TABLE[0].data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_INIT_ISSUE: begin
                    r_state     <= S_INIT_WAIT;
                    r_seen_busy <= 1'b0;
                end
                S_INIT_WAIT: begin
                    if (w_done || w_timeout) begin
                        if (r_idx == INIT_IDX_W'(INIT_LEN - 1)) begin
                            r_init_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_state <= S_INIT_ISSUE;
                            r_c_en  <= 1'b1;
                            r_mode  <= wr_mode(w_next_entry.is_long);
                            r_addr  <= w_next_entry.addr;
                            r_data  <= w_next_entry.data;
                        end
                    end
                end
                S_IDLE: begin
                    if (w_irq_win) begin
                        r_state    <= S_ISSUE;
                        r_c_en     <= 1'b1;
                        r_mode     <= SHORT_RD;
                        r_addr     <= INTSTAT_ADDR;
                        r_data     <= '0;
                        r_cur_host <= 1'b0;
                        r_last_irq <= 1'b1;
                    end else if (i_host_req) begin
                        r_state    <= S_ISSUE;
                        r_c_en     <= 1'b1;
                        r_mode     <= rf_mode_e'({i_host_long, i_host_we});
                        r_addr     <= i_host_addr;
                        r_data     <= i_host_wdata;
                        r_cur_host <= 1'b1;
                        r_cur_we   <= i_host_we;
                        r_last_irq <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_state     <= S_WAIT;
                    r_seen_busy <= 1'b0;
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        if (r_cur_host) begin
                            r_host_ack <= 1'b1;
                            if (!r_cur_we) begin
                                r_host_rdata <= w_rd_byte;
                            end
                        end else begin
                            r_irq_valid  <= 1'b1;
                            r_irq_status <= w_rd_byte;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_RST_WAIT;
            endcase
        end
    end

    assign o_eng_c_en   = r_c_en;
    assign o_eng_mode   = r_mode;
    assign o_eng_addr   = r_addr;
    assign o_eng_data   = r_data;
    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;
    assign o_irq_valid  = r_irq_valid;
    assign o_irq_status = r_irq_status;
    assign o_init_done  = r_init_done;

endmodule
